// File: rtl/sigmoid_eval_if.sv
// Operand/coefficient/result bundle for sigmoid_eval.
// master: the environment (operand source, coefficient tables, result sink); slave: the evaluator.
interface sigmoid_eval_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [2:0]  seg;
    logic [15:0] coef0;
    logic [15:0] coef1;
    logic [15:0] coef2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    modport master (
        output in_valid, in_data, coef0, coef1, coef2, out_ready,
        input  in_ready, seg, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, coef0, coef1, coef2, out_ready,
        output in_ready, seg, out_valid, out_data
    );
endinterface

// File: rtl/sigmoid_eval.sv
// Piecewise-quadratic sigmoid: y = (c2*d + c1)*d + c0 over segment min(int|x|, 6), clamped to [0, 1].
// Define SIGMOID_SYMMETRY_EN to mirror negative x as 1 - y; otherwise the caller handles symmetry.
module sigmoid_eval (
    input logic          clk,
    input logic          rst_n,
    sigmoid_eval_if.slave bus
);

    localparam logic [15:0] One = 16'h0100;

    typedef enum logic [2:0] {StIdle, StLookup, StMac1, StMac2, StOut} state_e;

    state_e             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [15:0]        out_data_q;
    logic [2:0]         seg_q;
    logic [15:0]        abs_q;
    logic signed [15:0] d_q;
    logic signed [15:0] acc_q;
    logic signed [15:0] c0_q;
    logic signed [15:0] c1_q;
    logic signed [15:0] c2_q;
`ifdef SIGMOID_SYMMETRY_EN
    logic               sign_q;
`endif

    logic [15:0]        abs_in;
    logic [2:0]         seg_in;
    logic signed [15:0] mac1;
    logic signed [15:0] mac2;
    logic [15:0]        y_pos;
    logic [15:0]        out_val;

    always_comb begin
        abs_in = bus.in_data;
        // -0x8000 has no positive Q8.8 counterpart; saturate it
        if (bus.in_data[15]) begin
            abs_in = (bus.in_data == 16'h8000) ? 16'h7fff : (~bus.in_data + 16'd1);
        end
        seg_in = (abs_in[14:8] > 7'd5) ? 3'd6 : abs_in[10:8];

        mac1 = 16'((32'(c2_q) * 32'(d_q)) >>> 8) + c1_q;
        mac2 = 16'((32'(acc_q) * 32'(d_q)) >>> 8) + c0_q;

        if (seg_q == 3'd6) begin
            y_pos = One;
        end else if (mac2 < 16'sh0000) begin
            y_pos = 16'h0000;
        end else if (mac2 > 16'sh0100) begin
            y_pos = One;
        end else begin
            y_pos = mac2;
        end

`ifdef SIGMOID_SYMMETRY_EN
        out_val = sign_q ? (One - y_pos) : y_pos;
`else
        out_val = y_pos;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= 16'h0000;
            seg_q       <= 3'd0;
            abs_q       <= 16'h0000;
            d_q         <= 16'sh0000;
            acc_q       <= 16'sh0000;
            c0_q        <= 16'sh0000;
            c1_q        <= 16'sh0000;
            c2_q        <= 16'sh0000;
`ifdef SIGMOID_SYMMETRY_EN
            sign_q      <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid && in_ready_q) begin
                        abs_q      <= abs_in;
                        seg_q      <= seg_in;
`ifdef SIGMOID_SYMMETRY_EN
                        sign_q     <= bus.in_data[15];
`endif
                        in_ready_q <= 1'b0;
                        state_q    <= StLookup;
                    end
                end
                StLookup: begin
                    // Coefficient tables have settled on seg_q by now
                    c0_q    <= bus.coef0;
                    c1_q    <= bus.coef1;
                    c2_q    <= bus.coef2;
                    d_q     <= abs_q - {5'd0, seg_q, 8'd0};
                    state_q <= StMac1;
                end
                StMac1: begin
                    acc_q   <= mac1;
                    state_q <= StMac2;
                end
                StMac2: begin
                    acc_q       <= mac2;
                    out_data_q  <= out_val;
                    out_valid_q <= 1'b1;
                    state_q     <= StOut;
                end
                StOut: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.seg       = seg_q;

endmodule

// File: tb/tb_sigmoid_eval.sv
// Self-checking bench for sigmoid_eval: directed vector table, handshake/reset sequences and
// randomized operands/coefficients against an arithmetic reference model.
module tb_sigmoid_eval;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sigmoid_eval_if bus ();

    sigmoid_eval dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] c0_tab [8];
    logic [15:0] c1_tab [8];
    logic [15:0] c2_tab [8];

    assign bus.coef0 = c0_tab[bus.seg];
    assign bus.coef1 = c1_tab[bus.seg];
    assign bus.coef2 = c2_tab[bus.seg];

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [15:0] x;
        logic [15:0] c0;
        logic [2:0]  seg;
        logic [15:0] y;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_coefs(input logic [15:0] c0);
        for (int i = 0; i < 8; i++) begin
            c0_tab[i] = c0;
            c1_tab[i] = 16'h0040;
            c2_tab[i] = 16'h0000;
        end
    endtask

    function automatic longint wrap16(input longint v);
        longint m;
        m = v & 64'hffff;
        return (m >= 32768) ? m - 65536 : m;
    endfunction

    function automatic longint floor256(input longint v);
        return (v >= 0) ? v / 256 : -((-v + 255) / 256);
    endfunction

    // sigmoid value expected from the current coefficient tables
    function automatic logic [15:0] model(input logic [15:0] x);
        longint xs, ax, k, d, a, y;
        xs = longint'($signed(x));
        ax = (xs < 0) ? -xs : xs;
        if (ax > 32767) ax = 32767;
        k = ax / 256;
        if (k > 6) k = 6;
        if (k == 6) begin
            y = 256;
        end else begin
            d = ax - 256 * k;
            a = wrap16(floor256(longint'($signed(c2_tab[k])) * d) + longint'($signed(c1_tab[k])));
            a = wrap16(floor256(a * d) + longint'($signed(c0_tab[k])));
            y = (a < 0) ? 0 : ((a > 256) ? 256 : a);
        end
`ifdef SIGMOID_SYMMETRY_EN
        if (xs < 0) y = 256 - y;
`endif
        return 16'(y);
    endfunction

    // Waits for in_ready, presents x, returns at #1 after the edge on which out_valid is seen
    task automatic start_op(input logic [15:0] x, output logic [2:0] seg_seen, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", {15'd0, bus.in_ready}, 16'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
        seg_seen     = bus.seg;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [2:0]  sg;
        int          lat;
        logic [15:0] res;
        logic [15:0] x;
        int          seen;

        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.out_ready = 1'b0;
        set_coefs(16'h0080);

        vecs[0] = '{"half",       16'h0080, 16'h0080, 3'd0, 16'h00A0};
`ifdef SIGMOID_SYMMETRY_EN
        vecs[1] = '{"neg_half",   16'hFF80, 16'h0080, 3'd0, 16'h0060};
        vecs[3] = '{"neg_seven",  16'hF900, 16'h0080, 3'd6, 16'h0000};
        vecs[4] = '{"most_neg",   16'h8000, 16'h0080, 3'd6, 16'h0000};
`else
        vecs[1] = '{"neg_half",   16'hFF80, 16'h0080, 3'd0, 16'h00A0};
        vecs[3] = '{"neg_seven",  16'hF900, 16'h0080, 3'd6, 16'h0100};
        vecs[4] = '{"most_neg",   16'h8000, 16'h0080, 3'd6, 16'h0100};
`endif
        vecs[2] = '{"seven",      16'h0700, 16'h0080, 3'd6, 16'h0100};
        vecs[5] = '{"clamp_hi",   16'h0000, 16'h0200, 3'd0, 16'h0100};
        vecs[6] = '{"clamp_lo",   16'h0000, 16'hFF00, 3'd0, 16'h0000};
        vecs[7] = '{"one_half",   16'h0180, 16'h0080, 3'd1, 16'h00A0};
        vecs[8] = '{"seg5_top",   16'h05FF, 16'h0080, 3'd5, 16'h00BF};
        vecs[9] = '{"six",        16'h0600, 16'h0080, 3'd6, 16'h0100};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_flags", {14'd0, bus.out_valid, bus.in_ready}, 16'h0001);
        check("rst_data", bus.out_data, 16'h0000);
        check("rst_seg", {13'd0, bus.seg}, 16'h0000);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            set_coefs(vecs[i].c0);
            start_op(vecs[i].x, sg, lat);
            check({vecs[i].name, "_seg"}, {13'd0, sg}, {13'd0, vecs[i].seg});
            check({vecs[i].name, "_lat"}, 16'(lat), 16'd3);
            check({vecs[i].name, "_y"}, bus.out_data, vecs[i].y);
            finish_op();
        end

        // Backpressure: result holds, in_valid pulses ignored
        set_coefs(16'h0080);
        start_op(16'h0080, sg, lat);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.in_data  = 16'($urandom);
            @(posedge clk);
            #1;
            check("hold_data", bus.out_data, 16'h00A0);
            check("hold_flags", {14'd0, bus.out_valid, bus.in_ready}, 16'h0002);
        end
        bus.in_valid = 1'b0;
        finish_op();
        check("release_flags", {14'd0, bus.out_valid, bus.in_ready}, 16'h0001);
        @(posedge clk);
        #1;
        check("idle_flags", {14'd0, bus.out_valid, bus.in_ready}, 16'h0001);

        // Reset during MAC1
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0080;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_flags", {14'd0, bus.out_valid, bus.in_ready}, 16'h0001);
        check("midrst_data", bus.out_data, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        check("no_stale", 16'(seen), 16'd0);
        start_op(16'h0180, sg, lat);
        check("resume_lat", 16'(lat), 16'd3);
        check("resume_y", bus.out_data, 16'h00A0);
        finish_op();

        // Random operands and coefficient tables
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 8; i++) begin
                c0_tab[i] = 16'($urandom);
                c1_tab[i] = 16'($urandom);
                c2_tab[i] = 16'($urandom);
            end
            x = 16'($urandom_range(0, 16'h0700));
            if ($urandom_range(0, 1) == 1) x = ~x + 16'd1;
            start_op(x, sg, lat);
            check("rand_lat", 16'(lat), 16'd3);
            check("rand_y", bus.out_data, model(x));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            finish_op();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
